// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with IF/ID pipeline register
// Assembles one- and two-word instructions and presents registered fields to decode.
module fetch_unit #(
    parameter int              PC_W         = 16,
    parameter int              INSTR_W      = 16,
    parameter logic [PC_W-1:0] RESET_VECTOR = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    flush_target,
    output logic [6:0]         opcode,
    output logic [2:0]         rsrc,
    output logic [2:0]         rdst,
    output logic [15:0]        imm,
    output logic [PC_W-1:0]    instr_pc,
    output logic               valid,
    output logic               halted
);

    localparam logic [6:0] OP_IADD = 7'b0100000;
    localparam logic [6:0] OP_LDM  = 7'b0110101;
    localparam logic [6:0] OP_LDD  = 7'b0100010;
    localparam logic [6:0] OP_HLT  = 7'b1100001;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_IMM = 2'd1,
        HALTED    = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic [6:0]      hold_opcode, hold_opcode_n;
    logic [2:0]      hold_rsrc, hold_rsrc_n;
    logic [2:0]      hold_rdst, hold_rdst_n;
    logic [PC_W-1:0] hold_pc, hold_pc_n;
    logic [6:0]      opcode_n;
    logic [2:0]      rsrc_n, rdst_n;
    logic [15:0]     imm_n;
    logic [PC_W-1:0] instr_pc_n;
    logic            valid_n, halted_n;

    logic [6:0] w_opcode;
    logic [2:0] w_rsrc, w_rdst;
    logic       w_two_word;
    logic       unused_low_bits;

    assign w_opcode        = imem_data[INSTR_W-1 -: 7];
    assign w_rsrc          = imem_data[INSTR_W-8 -: 3];
    assign w_rdst          = imem_data[INSTR_W-11 -: 3];
    assign unused_low_bits = ^imem_data[INSTR_W-14:0];
    assign w_two_word      = (w_opcode == OP_IADD) || (w_opcode == OP_LDM) ||
                             (w_opcode == OP_LDD);
    assign imem_addr       = pc;

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        hold_opcode_n = hold_opcode;
        hold_rsrc_n   = hold_rsrc;
        hold_rdst_n   = hold_rdst;
        hold_pc_n     = hold_pc;
        opcode_n      = opcode;
        rsrc_n        = rsrc;
        rdst_n        = rdst;
        imm_n         = imm;
        instr_pc_n    = instr_pc;
        valid_n       = valid;
        halted_n      = halted;

        // HALTED is checked first so stall and flush cannot wake the stage.
        if (state == HALTED) begin
            valid_n  = 1'b0;
            halted_n = 1'b1;
        end else if (flush) begin
            valid_n = 1'b0;
            pc_n    = flush_target;
            state_n = FETCH_OP;
        end else if (!stall) begin
            pc_n = pc + 1'b1;
            if (state == FETCH_OP) begin
                if (w_two_word) begin
                    hold_opcode_n = w_opcode;
                    hold_rsrc_n   = w_rsrc;
                    hold_rdst_n   = w_rdst;
                    hold_pc_n     = pc;
                    valid_n       = 1'b0;
                    state_n       = FETCH_IMM;
                end else begin
                    opcode_n   = w_opcode;
                    rsrc_n     = w_rsrc;
                    rdst_n     = w_rdst;
                    imm_n      = 16'h0000;
                    instr_pc_n = pc;
                    valid_n    = 1'b1;
                    state_n    = (w_opcode == OP_HLT) ? HALTED : FETCH_OP;
                end
            end else begin
                opcode_n   = hold_opcode;
                rsrc_n     = hold_rsrc;
                rdst_n     = hold_rdst;
                imm_n      = 16'(imem_data);
                instr_pc_n = hold_pc;
                valid_n    = 1'b1;
                state_n    = FETCH_OP;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH_OP;
            pc          <= RESET_VECTOR;
            hold_opcode <= '0;
            hold_rsrc   <= '0;
            hold_rdst   <= '0;
            hold_pc     <= '0;
            opcode      <= '0;
            rsrc        <= '0;
            rdst        <= '0;
            imm         <= '0;
            instr_pc    <= '0;
            valid       <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            hold_opcode <= hold_opcode_n;
            hold_rsrc   <= hold_rsrc_n;
            hold_rdst   <= hold_rdst_n;
            hold_pc     <= hold_pc_n;
            opcode      <= opcode_n;
            rsrc        <= rsrc_n;
            rdst        <= rdst_n;
            imm         <= imm_n;
            instr_pc    <= instr_pc_n;
            valid       <= valid_n;
            halted      <= halted_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        flush;
    logic [15:0] flush_target;
    logic [6:0]  opcode;
    logic [2:0]  rsrc, rdst;
    logic [15:0] imm;
    logic [15:0] instr_pc;
    logic        valid, halted;

    logic [15:0] mem [0:65535];
    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] OP_NOT  = 7'b0010001;
    localparam logic [6:0] OP_INC  = 7'b0000011;
    localparam logic [6:0] OP_ADD  = 7'b0000001;
    localparam logic [6:0] OP_IADD = 7'b0100000;
    localparam logic [6:0] OP_LDM  = 7'b0110101;
    localparam logic [6:0] OP_LDD  = 7'b0100010;
    localparam logic [6:0] OP_HLT  = 7'b1100001;

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr];

    fetch_unit dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .flush(flush), .flush_target(flush_target),
        .opcode(opcode), .rsrc(rsrc), .rdst(rdst), .imm(imm),
        .instr_pc(instr_pc), .valid(valid), .halted(halted)
    );

    function automatic logic [15:0] enc(input logic [6:0] op, input logic [2:0] s, input logic [2:0] d);
        return {op, s, d, 3'b000};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_instr(input string tag, input logic [6:0] op, input logic [2:0] s,
                                input logic [2:0] d, input logic [15:0] im, input logic [15:0] ipc);
        check({tag, "_valid"}, valid, 1);
        check({tag, "_op"}, opcode, op);
        check({tag, "_rsrc"}, rsrc, s);
        check({tag, "_rdst"}, rdst, d);
        check({tag, "_imm"}, imm, im);
        check({tag, "_pc"}, instr_pc, ipc);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[0]     = enc(OP_NOT, 3'd1, 3'd2);
        mem[1]     = enc(OP_INC, 3'd0, 3'd5);
        mem[2]     = enc(OP_ADD, 3'd6, 3'd7);
        mem[3]     = enc(OP_INC, 3'd3, 3'd4);
        mem[4]     = enc(OP_LDM, 3'd2, 3'd1);
        mem[5]     = 16'hBEEF;
        mem[6]     = enc(OP_ADD, 3'd4, 3'd3);
        mem[7]     = enc(OP_HLT, 3'd0, 3'd0);
        mem[16'h20] = enc(OP_ADD, 3'd1, 3'd1);
        mem[16'h30] = enc(OP_IADD, 3'd5, 3'd6);
        mem[16'h31] = 16'h1234;
        mem[16'hFFFF] = enc(OP_LDD, 3'd7, 3'd2);

        reset = 1'b0; stall = 1'b0; flush = 1'b0; flush_target = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_valid", valid, 0);
        check("rst_halted", halted, 0);
        check("rst_fields", {opcode, rsrc, rdst, imm, instr_pc}, 0);
        reset = 1'b1;

        tick(); expect_instr("c1", OP_NOT, 3'd1, 3'd2, 16'h0, 16'h0);
        tick(); expect_instr("c2", OP_INC, 3'd0, 3'd5, 16'h0, 16'h1);
        tick(); expect_instr("c3", OP_ADD, 3'd6, 3'd7, 16'h0, 16'h2);
        tick(); expect_instr("c4", OP_INC, 3'd3, 3'd4, 16'h0, 16'h3);
        check("c4_addr", imem_addr, 16'h4);
        tick(); check("ldm_bubble", valid, 0); check("ldm_addr1", imem_addr, 16'h5);
        tick(); expect_instr("ldm", OP_LDM, 3'd2, 3'd1, 16'hBEEF, 16'h4);
        check("ldm_addr2", imem_addr, 16'h6);
        tick(); expect_instr("add6", OP_ADD, 3'd4, 3'd3, 16'h0, 16'h6);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", valid, 1);
            check("stall_op", opcode, OP_ADD);
            check("stall_pc", instr_pc, 16'h6);
            check("stall_addr", imem_addr, 16'h7);
        end
        stall = 1'b0;

        tick(); expect_instr("hlt", OP_HLT, 3'd0, 3'd0, 16'h0, 16'h7);
        check("hlt_not_halted", halted, 0);
        check("hlt_addr", imem_addr, 16'h8);
        for (int i = 0; i < 10; i++) begin
            flush = (i % 2 == 0); flush_target = 16'h0020;
            tick();
            check("halt_valid", valid, 0);
            check("halt_flag", halted, 1);
            check("halt_addr", imem_addr, 16'h8);
        end
        flush = 1'b0;

        reset = 1'b0; #1;
        check("rst_async_addr", imem_addr, 16'h0000);
        check("rst_async_halted", halted, 0);
        tick(); reset = 1'b1;

        for (int pass = 0; pass < 2; pass++) begin
            flush = 1'b1; flush_target = 16'h0030;
            tick(); check("fl_jump_valid", valid, 0); check("fl_jump_addr", imem_addr, 16'h30);
            flush = 1'b0;
            tick(); check("fl_imm_bubble", valid, 0); check("fl_imm_addr", imem_addr, 16'h31);
            flush = 1'b1; stall = (pass == 1); flush_target = 16'h0020;
            tick(); check("fl_valid", valid, 0); check("fl_addr", imem_addr, 16'h20);
            flush = 1'b0; stall = 1'b0;
            tick(); expect_instr("fl_after", OP_ADD, 3'd1, 3'd1, 16'h0, 16'h20);
        end

        flush = 1'b1; flush_target = 16'hFFFF;
        tick(); check("wr_addr0", imem_addr, 16'hFFFF);
        flush = 1'b0;
        tick(); check("wr_bubble", valid, 0); check("wr_addr1", imem_addr, 16'h0000);
        tick(); expect_instr("wr_ldd", OP_LDD, 3'd7, 3'd2, 16'h2250, 16'hFFFF);
        check("wr_addr2", imem_addr, 16'h0001);

        flush = 1'b1; flush_target = 16'hFFFF;
        tick(); flush = 1'b0;
        tick(); check("mid_imm_addr", imem_addr, 16'h0000);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_fields", {opcode, rsrc, rdst, imm, instr_pc}, 0);
        check("mid_rst_addr", imem_addr, 16'h0000);
        tick(); reset = 1'b1;
        tick(); expect_instr("post_rst", OP_NOT, 3'd1, 3'd2, 16'h0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage and IF/ID pipeline register that feed the control unit's 7-bit opcode input.
- Drives the PC onto an asynchronous-read instruction memory.
- Assembles one-word and two-word (immediate-carrying) instructions.
- Presents registered opcode, register fields and immediate to decode.
- Honours downstream stall and flush/redirect; freezes permanently on HLT until reset.

Parameters:
PC_W, 16, program counter and instruction-memory address width
INSTR_W, 16, instruction word width; the opcode is bits [15:9]
RESET_VECTOR, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
imem_addr  output  PC_W  instruction-memory address; combinational copy of the internal PC
imem_data  input  INSTR_W  instruction-memory read data; valid in the same cycle as imem_addr
stall  input  1  hold all stage state (from hazard logic)
flush  input  1  discard the in-flight instruction and redirect the PC
flush_target  input  PC_W  new PC, used when flush=1
opcode  output  7  registered opcode to the control unit
rsrc  output  3  registered source register field, bits [8:6]
rdst  output  3  registered destination register field, bits [5:3]
imm  output  16  registered immediate; 0 for one-word instructions
instr_pc  output  PC_W  address of the first word of the presented instruction
valid  output  1  IF/ID register holds a real instruction
halted  output  1  high while in the HALTED state

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_VECTOR, state=FETCH_OP, valid=0, halted=0.
  - opcode, rsrc, rdst, imm and instr_pc are all 0.
  - Reset asserted mid-instruction (including in FETCH_IMM) abandons the instruction.
- Two-word opcodes: 7'b0100000 (IADD), 7'b0110101 (LDM), 7'b0100010 (LDD). All others are one word.
- HLT opcode: 7'b1100001.
- Priority each cycle: flush > stall > normal.
- FETCH_OP, normal operation, word w=imem_data at pc:
  - One-word, non-HLT: next cycle opcode/rsrc/rdst come from w, imm=0, instr_pc=pc, valid=1; pc=pc+1; stay in FETCH_OP.
  - Two-word: latch w's fields and pc into holding registers; valid=0 (bubble); pc=pc+1; go to FETCH_IMM.
  - HLT: present it as one-word with valid=1; pc=pc+1; go to HALTED.
- FETCH_IMM, normal operation:
  - imm=imem_data; present the held fields and held pc with valid=1; pc=pc+1; go to FETCH_OP.
- HALTED:
  - valid=0, halted=1, pc frozen; stall and flush are ignored. Only reset exits.
  - HLT is visible for exactly one valid cycle before halted rises. halted=1 starts from the cycle after the HLT valid cycle.
- Stall=1 (no flush): pc, state, holding registers and every output hold their values. The presented instruction and valid are unchanged.
- Flush=1 in FETCH_OP or FETCH_IMM:
  - Next cycle valid=0, pc=flush_target, state=FETCH_OP.
  - A partially fetched two-word instruction is discarded.
  - Flush overrides a simultaneous stall.
- PC arithmetic is modulo 2^PC_W: 16'hFFFF+1=16'h0000. A two-word instruction at 16'hFFFF takes its immediate from address 0; its instr_pc stays 16'hFFFF.
- Latency: a one-word instruction appears 1 cycle after its fetch; a two-word instruction appears 2 cycles after its first word.
- Sustained throughput: 1 instruction/cycle for one-word, 1 per 2 cycles for two-word.

Test Plan:
- Reset, then imem holds NOT(7'b0010001,rsrc=1,rdst=2), INC, ADD at 0..2 -> valid=1 on cycles 1,2,3; opcodes 0010001,0000011,0000001; instr_pc 0,1,2; imm=0.
- LDM at 4 with word 5=16'hBEEF -> cycle after fetch: valid=0; next cycle: opcode=0110101, imm=16'hBEEF, instr_pc=4; then pc=6.
- Stall held 3 cycles while ADD is presented -> opcode, instr_pc, imem_addr and valid constant for 3 cycles; fetch resumes at the next address afterward.
- Flush with flush_target=16'h0020 while in FETCH_IMM of IADD -> next cycle valid=0, imem_addr=16'h0020, IADD never presented; flush+stall together behave identically.
- HLT at 7 -> one valid cycle with opcode=1100001, then halted=1, valid=0, imem_addr=8 frozen for 10 cycles despite flush pulses; reset pulse returns pc to RESET_VECTOR.
- LDD at 16'hFFFF, imm at 16'h0000 -> opcode=0100010, instr_pc=16'hFFFF, imm=mem[0], pc wraps to 1; asynchronous reset asserted mid-FETCH_IMM clears valid immediately without waiting for clk.
